// File: rtl/div_pkg.sv
// Shared widths and FSM encoding for the 12-by-6 sequential divider.
package div_pkg;

  localparam int DVD_W = 12;
  localparam int DVS_W = 6;
  localparam int CNT_W = $clog2(DVD_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/div_restore_step.sv
// One combinational restoring-division step.
module div_restore_step #(
  parameter int DVS_W = div_pkg::DVS_W
) (
  input  logic [DVS_W:0]   rem_in,
  input  logic             bit_in,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVS_W:0]   rem_out,
  output logic             q_bit
);

  logic [DVS_W:0] shifted;
  logic [DVS_W:0] dvs_ext;

  // rem_in is always below divisor, so its top bit carries no data
  assign shifted = {DVS_W'(rem_in), bit_in};
  assign dvs_ext = {1'b0, divisor};
  assign q_bit   = (shifted >= dvs_ext);
  assign rem_out = q_bit ? (shifted - dvs_ext) : shifted;

endmodule

// File: rtl/seq_divider_12by6.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
module seq_divider_12by6 #(
  parameter int DVD_W = div_pkg::DVD_W,
  parameter int DVS_W = div_pkg::DVS_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             div_by_zero
);

  import div_pkg::*;

  localparam int CW = $clog2(DVD_W + 1);

  state_t           state;
  state_t           nxt;
  logic [DVD_W-1:0] dvd_q;
  logic [DVS_W-1:0] dvs_q;
  logic [DVS_W:0]   rem_q;
  logic [DVD_W-1:0] quo_q;
  logic [CW-1:0]    cnt;
  logic [DVS_W:0]   rem_nx;
  logic             q_bit;
  logic [DVD_W-1:0] quo_nx;
  logic             accept;
  logic             zero;
  logic             last;

  div_restore_step #(
    .DVS_W(DVS_W)
  ) u_step (
    .rem_in (rem_q),
    .bit_in (dvd_q[DVD_W-1]),
    .divisor(dvs_q),
    .rem_out(rem_nx),
    .q_bit  (q_bit)
  );

  assign accept = start && (state != RUN);
  assign zero   = (divisor == '0);
  assign last   = (state == RUN) && (cnt == CW'(DVD_W - 1));
  assign quo_nx = (quo_q << 1) | DVD_W'(q_bit);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (start) nxt = zero ? DONE : RUN;
      end
      RUN: begin
        if (last) nxt = DONE;
      end
      DONE: begin
        if (start) nxt = zero ? DONE : RUN;
        else       nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // working registers: operands, partial remainder, quotient, counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt   <= '0;
    end else if (accept) begin
      dvd_q <= dividend;
      dvs_q <= divisor;
      rem_q <= '0;
      quo_q <= '0;
      cnt   <= '0;
    end else if (state == RUN) begin
      dvd_q <= dvd_q << 1;
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      cnt   <= cnt + CW'(1);
    end
  end

  // results change only on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept && zero) begin
      quotient    <= '1;
      remainder   <= '0;
      div_by_zero <= 1'b1;
    end else if (last) begin
      quotient    <= quo_nx;
      remainder   <= DVS_W'(rem_nx);
      div_by_zero <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_divider_12by6.sv
// Bench for seq_divider_12by6: arithmetic reference model plus directed cases.
module tb_seq_divider_12by6;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] dividend;
  logic [5:0]  divisor;
  logic        busy;
  logic        done;
  logic [11:0] quotient;
  logic [5:0]  remainder;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;
  int n_fin = 0;

  int          m_left;
  bit          m_done;
  logic [11:0] m_q, p_q, m_a, p_a;
  logic [5:0]  m_r, p_r, m_d, p_d;
  bit          m_z;

  seq_divider_12by6 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: a division takes 12 edges after acceptance, zero divisor 0
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_done = 0;
      m_q = '0; m_r = '0; m_z = 0;
      m_a = '0; m_d = '0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1;
          m_q = p_q; m_r = p_r; m_z = 0;
          m_a = p_a; m_d = p_d;
        end
      end else if (start) begin
        if (divisor == 0) begin
          m_done = 1;
          m_q = 12'hFFF; m_r = '0; m_z = 1;
          m_a = dividend; m_d = '0;
        end else begin
          p_a = dividend;
          p_d = divisor;
          p_q = dividend / divisor;
          p_r = dividend % divisor;
          m_left = 12;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", busy, m_left > 0);
      chk("done", done, m_done);
      chk("quotient", quotient, m_q);
      chk("remainder", remainder, m_r);
      chk("div_by_zero", div_by_zero, m_z);
      if (done && !div_by_zero) begin
        chk("mul_identity", 32'(quotient) * 32'(m_d) + 32'(remainder),
            32'(m_a));
        chk("rem_lt_div", remainder < m_d, 1);
        n_fin++;
      end
    end
  end

  task automatic wait_done(output int n);
    bit got = 0;
    n = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        n = i;
      end
    end
  endtask

  task automatic do_op(input logic [11:0] a, input logic [5:0] b,
                       input int lat, input logic [11:0] eq,
                       input logic [5:0] er, input bit ez,
                       input string nm);
    int n;
    @(posedge clk);
    #1;
    start = 1; dividend = a; divisor = b;
    @(posedge clk);
    #1;
    start = 0;
    dividend = 12'($urandom);
    divisor = 6'($urandom);
    wait_done(n);
    chk({nm, "_latency"}, n, lat);
    chk({nm, "_q"}, quotient, eq);
    chk({nm, "_r"}, remainder, er);
    chk({nm, "_dbz"}, div_by_zero, ez);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int fin0;
    int cycles;
    rst_n = 0; start = 0; dividend = '0; divisor = '0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    #20;
    @(negedge clk);
    rst_n = 1;

    do_op(12'd1242, 6'd46, 13, 12'd27, 6'd0, 0, "d1242_46");
    do_op(12'd1242, 6'd10, 13, 12'd124, 6'd2, 0, "d1242_10");
    // start held through DONE begins the next division at once
    start = 1; dividend = 12'd5; divisor = 6'd7;
    @(posedge clk);
    #1;
    start = 0;
    wait_done(n);
    chk("b2b_latency", n, 13);
    chk("b2b_q", quotient, 0);
    chk("b2b_r", remainder, 5);
    do_op(12'd4095, 6'd63, 13, 12'd65, 6'd0, 0, "d4095_63");
    do_op(12'd100, 6'd0, 1, 12'd4095, 6'd0, 1, "d100_0");
    do_op(12'd4095, 6'd1, 13, 12'd4095, 6'd0, 0, "d4095_1");

    // reset in flight with an ignored start
    @(posedge clk);
    #1;
    start = 1; dividend = 12'd1242; divisor = 6'd46;
    @(posedge clk);
    #1;
    start = 0;
    repeat (4) @(posedge clk);
    #1;
    start = 1; dividend = 12'd7; divisor = 6'd1;
    @(posedge clk);
    #1;
    start = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("inflight_busy", busy, 1);
    chk("inflight_q_held", quotient, 12'd4095);
    rst_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_q", quotient, 0);
    chk("arst_r", remainder, 0);
    chk("arst_dbz", div_by_zero, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst_no_done", done, 0);
    end
    rst_n = 1;
    start = 1; dividend = 12'd4095; divisor = 6'd63;
    @(posedge clk);
    #1;
    start = 0;
    wait_done(n);
    chk("post_rst_latency", n, 13);
    chk("post_rst_q", quotient, 12'd65);

    // random traffic, start also toggled while running
    fin0 = n_fin;
    cycles = 0;
    while ((n_fin - fin0) < 1000 && cycles < 60000) begin
      @(posedge clk);
      #1;
      cycles++;
      start = ($urandom_range(0, 2) == 0);
      dividend = 12'($urandom);
      divisor = ($urandom_range(0, 15) == 0) ? 6'd0
                : 6'($urandom_range(1, 63));
    end
    chk("random_completions", (n_fin - fin0) >= 1000, 1);
    start = 0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_divider_12by6.md
SEQ_DIVIDER_12BY6 -- requirements
Module: seq_divider_12by6

Interface
REQ-001 Parameter DVD_W, default 12, dividend and quotient width; equals the product width of the 6-bit multiplier.
REQ-002 Parameter DVS_W, default 6, divisor and remainder width.
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  request to begin a division; sampled on the rising clk edge.
REQ-006 Port dividend  input  DVD_W  unsigned dividend; sampled only when start is accepted.
REQ-007 Port divisor  input  DVS_W  unsigned divisor; sampled only when start is accepted.
REQ-008 Port busy  output  1  high while a division is in progress (state RUN).
REQ-009 Port done  output  1  one-cycle pulse; result outputs are valid in that cycle.
REQ-010 Port quotient  output  DVD_W  unsigned quotient.
REQ-011 Port remainder  output  DVS_W  unsigned remainder.
REQ-012 Port div_by_zero  output  1  high with done when the latched divisor was 0.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 start SHALL be accepted only in IDLE or DONE; on acceptance the block latches dividend and divisor and clears the partial remainder and the iteration counter.
REQ-015 An accepted start with a nonzero divisor SHALL move the FSM to RUN; an accepted start with a zero divisor SHALL move it directly to DONE.
REQ-016 RUN SHALL perform one restoring step per cycle, MSB first: shift the partial remainder left by 1 and bring in the next dividend bit, then compare against the divisor.
REQ-017 If the shifted value is >= divisor, the step SHALL subtract the divisor and shift a 1 into the quotient; otherwise it SHALL shift in a 0.
REQ-018 The partial remainder SHALL be DVS_W+1 bits wide internally so that the shifted value never overflows.
REQ-019 RUN SHALL last exactly DVD_W cycles; after the last step the FSM SHALL enter DONE.
REQ-020 Latency: with start accepted at edge k and a nonzero divisor, done SHALL be high in the cycle following edge k+DVD_W (12 cycles).
REQ-021 Latency: with a zero divisor, done SHALL be high in the cycle following edge k.
REQ-022 DONE SHALL last one cycle; done=1 only in DONE. Without start the FSM returns to IDLE; with start, REQ-014 and REQ-015 apply (back-to-back operation).
REQ-023 On divide-by-zero: quotient = all ones, remainder = 0, div_by_zero = 1.
REQ-024 A start asserted while in RUN SHALL be ignored; it must not disturb the operation in flight.
REQ-025 quotient, remainder and div_by_zero SHALL hold their last result until the next completion; they SHALL NOT change during RUN.
REQ-026 For every nonzero divisor: quotient*divisor + remainder == dividend and remainder < divisor.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
REQ-028 Reset asserted during RUN SHALL abandon the operation; no done pulse is produced for it.
REQ-029 After rst_n deasserts, the first rising edge SHALL accept a start.

Structure
REQ-030 Package div_pkg SHALL hold DVD_W, DVS_W, the counter width ($clog2(DVD_W+1)) and the state enumeration.
REQ-031 The restoring step SHALL be a combinational sub-module, div_restore_step: inputs are the partial remainder, the incoming dividend bit and the divisor; outputs are the new partial remainder and the quotient bit.
REQ-032 The top module SHALL contain only the FSM, the counter and the operand and result registers; target size is 120-400 RTL lines.

Verification
REQ-033 Test: dividend=1242, divisor=46 -> 12 cycles later done=1, quotient=27, remainder=0, div_by_zero=0.
REQ-034 Test: dividend=1242, divisor=10 -> quotient=124, remainder=2; then 5/7 back-to-back (start held during DONE) -> quotient=0, remainder=5.
REQ-035 Test: dividend=4095, divisor=63 -> quotient=65, remainder=0.
REQ-036 Test: dividend=100, divisor=0 -> 1 cycle later done=1, div_by_zero=1, quotient=4095, remainder=0.
REQ-037 Test: start with 1242/46, pulse start with 7/1 at cycle 5 of RUN, pull rst_n low at cycle 8 -> the second start has no effect; reset zeroes all outputs; no done pulse.
REQ-038 Test: 1000 random operand pairs with nonzero divisors -> every result satisfies REQ-026; results are cross-checked against the 6-bit multiplier product.
